// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
module multicycle_controller #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  input  logic            is_mem_read,
  input  logic            is_mem_write,
  input  logic            is_reg_write,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            if_en,
  output logic            id_en,
  output logic            ex_en,
  output logic            rf_we,
  output logic            pc_we,
  output logic            busy,
  output logic            halted,
  output logic            timeout_err,
  output logic [2:0]      stage,
  output logic [XLEN-1:0] retired
);

  localparam int WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WLIMIT = WCW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic           f_rd, f_wr, f_rw;
  logic           timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WLIMIT);

  // wait_nxt falls back to zero in every non-waiting cycle, so each entry
  // to FETCH or MEMORY starts from a cleared counter
  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready)       state_nxt = S_DECODE;
        else if (timeout_hit) state_nxt = S_ERROR;
        else                  wait_nxt  = wait_cnt + WCW'(1);
      end
      S_DECODE:    state_nxt = halt_req ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_nxt = (f_rd || f_wr) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (dmem_ready)       state_nxt = S_WRITEBACK;
        else if (timeout_hit) state_nxt = S_ERROR;
        else                  wait_nxt  = wait_cnt + WCW'(1);
      end
      S_WRITEBACK: state_nxt = S_FETCH;
      default:     state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      f_rd     <= 1'b0;
      f_wr     <= 1'b0;
      f_rw     <= 1'b0;
      retired  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == S_DECODE) begin
        f_rd <= is_mem_read;
        f_wr <= is_mem_write;
        f_rw <= is_reg_write;
      end
      if (state == S_WRITEBACK) retired <= retired + XLEN'(1);
    end
  end

  // if_en is the only output allowed to follow an input combinationally
  assign imem_req    = (state == S_FETCH);
  assign if_en       = (state == S_FETCH) && imem_ready;
  assign id_en       = (state == S_DECODE);
  assign ex_en       = (state == S_EXECUTE);
  assign dmem_req    = (state == S_MEMORY);
  assign dmem_we     = (state == S_MEMORY) && f_wr;
  assign rf_we       = (state == S_WRITEBACK) && f_rw;
  assign pc_we       = (state == S_WRITEBACK);
  assign busy        = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXECUTE) ||
                       (state == S_MEMORY) || (state == S_WRITEBACK);
  assign halted      = (state == S_HALT);
  assign timeout_err = (state == S_ERROR);
  assign stage       = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, halt_req = 1'b0;
  logic is_mem_read = 1'b0, is_mem_write = 1'b0, is_reg_write = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, if_en, id_en, ex_en, rf_we, pc_we;
  logic busy, halted, timeout_err;
  logic [2:0] stage;
  logic [XLEN-1:0] retired;

  always #5 clk = ~clk;

  multicycle_controller #(.XLEN(XLEN), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .is_mem_read(is_mem_read), .is_mem_write(is_mem_write), .is_reg_write(is_reg_write),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .rf_we(rf_we), .pc_we(pc_we),
    .busy(busy), .halted(halted), .timeout_err(timeout_err),
    .stage(stage), .retired(retired)
  );

  // kind: 0 retired normally, 1 halted, 2 timed out
  typedef struct {
    int kind; int cycles; int id; int ex; int mreq; int mwe; int rf; int ret;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // monitor: accumulates per-instruction activity and scores it on completion
  initial begin
    int m_cyc, m_id, m_ex, m_mreq, m_mwe, m_rf;
    logic prev_halt, prev_err;
    exp_t e;
    m_cyc = 0; m_id = 0; m_ex = 0; m_mreq = 0; m_mwe = 0; m_rf = 0;
    prev_halt = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_cyc = 0; m_id = 0; m_ex = 0; m_mreq = 0; m_mwe = 0; m_rf = 0;
        prev_halt = 1'b0; prev_err = 1'b0;
      end else begin
        if (busy) m_cyc++;
        if (id_en) m_id++;
        if (ex_en) m_ex++;
        if (rf_we) m_rf++;
        if (dmem_req) begin
          m_mreq++;
          if (dmem_we) m_mwe++;
        end
        if (pc_we || (halted && !prev_halt) || (timeout_err && !prev_err)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("completion_kind", pc_we ? 0 : (halted ? 1 : 2), e.kind);
            chk("cycles", m_cyc, e.cycles);
            chk("id_en_cycles", m_id, e.id);
            chk("ex_en_cycles", m_ex, e.ex);
            chk("dmem_req_cycles", m_mreq, e.mreq);
            chk("dmem_we_cycles", m_mwe, e.mwe);
            chk("rf_we_cycles", m_rf, e.rf);
            chk("retired", retired, e.ret);
            if (e.kind == 2) chk("req_after_timeout", {imem_req, dmem_req}, 0);
          end
          m_cyc = 0; m_id = 0; m_ex = 0; m_mreq = 0; m_mwe = 0; m_rf = 0;
        end
        prev_halt = halted;
        prev_err  = timeout_err;
      end
    end
  end

  task automatic reset_start();
    rst = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {imem_req, dmem_req, dmem_we, if_en, id_en, ex_en, rf_we, pc_we,
                          busy, halted, timeout_err}, 0);
    chk("reset_retired", retired, 0);
    chk("reset_stage", stage, 0);
    exp_q.delete();
    exp_ret = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_stage", stage, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency", stage, 1);
  endtask

  task automatic check_sticky(input logic [2:0] s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("sticky_stage", stage, s);
  endtask

  // Drive one instruction from its first FETCH cycle; expectations come from
  // the cycle-cost rules: fetch waits+1, decode, execute, memory waits+1, writeback.
  task automatic run_instr(input bit rd, input bit wr, input bit rw, input bit hl,
                           input int iw, input int dw, input bit abort);
    exp_t e;
    int fc, mc, g;
    logic [2:0] st;
    bit mem;
    mem = rd | wr;
    fc = 0; mc = 0; g = 0;
    e.kind = 0; e.cycles = 0; e.id = 1; e.ex = 1; e.mreq = 0; e.mwe = 0; e.rf = 0;
    e.ret = exp_ret;
    if (iw > TMO) begin
      e.kind = 2; e.cycles = TMO + 1; e.id = 0; e.ex = 0;
    end else if (hl) begin
      e.kind = 1; e.cycles = iw + 2; e.ex = 0;
    end else if (mem && dw > TMO) begin
      e.kind = 2; e.mreq = TMO + 1; e.mwe = wr ? e.mreq : 0;
      e.cycles = iw + 1 + 2 + e.mreq;
    end else begin
      e.mreq = mem ? dw + 1 : 0;
      e.mwe = wr ? e.mreq : 0;
      e.rf = rw;
      e.cycles = iw + 1 + 2 + e.mreq + 1;
      if (!abort) exp_ret++;
    end
    if (!abort) exp_q.push_back(e);
    while (g < 200) begin
      st = stage;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      halt_req = 1'($urandom); is_mem_read = 1'($urandom);
      is_mem_write = 1'($urandom); is_reg_write = 1'($urandom);
      if (st == 3'd1) begin
        imem_ready = (fc == iw);
        fc++;
      end else if (st == 3'd2) begin
        halt_req = hl; is_mem_read = rd; is_mem_write = wr; is_reg_write = rw;
      end else if (st == 3'd4) begin
        if (abort && mc == 1) begin
          chk("retired_before_abort", retired, exp_ret);
          #2 rst = 1'b0;
          #1;
          chk("abort_dmem_req", dmem_req, 0);
          chk("abort_retired", retired, 0);
          chk("abort_stage", stage, 0);
          return;
        end
        dmem_ready = (mc == dw);
        mc++;
      end
      if (st == 3'd1) begin
        #1;
        chk("if_en", if_en, imem_ready);
      end
      @(negedge clk);
      g++;
      if (st == 3'd5 || halted || timeout_err) break;
    end
    if (g >= 200) chk("instr_cycle_bound", 0, 1);
  endtask

  initial begin
    reset_start();
    run_instr(0, 0, 1, 0, 0, 0, 0);
    run_instr(1, 0, 1, 0, 0, 3, 0);
    run_instr(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      run_instr(0, 0, 1'($urandom), 0, $urandom_range(0, 3), 0, 0);
    run_instr(1, 0, 1, 0, 0, 3, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold_after_reset", stage, 0);

    reset_start();
    run_instr(0, 0, 1, 1, 1, 0, 0);
    check_sticky(3'd6);
    reset_start();
    run_instr(0, 0, 1, 0, 5, 0, 0);
    check_sticky(3'd7);
    reset_start();
    run_instr(0, 0, 1, 0, 4, 0, 0);
    run_instr(1, 0, 1, 0, 0, 4, 0);
    run_instr(0, 1, 0, 0, 0, 5, 0);
    check_sticky(3'd7);

    reset_start();
    for (int i = 0; i < 60; i++) begin
      int r, iw, dw;
      bit rd, wr, rw, hl;
      r  = $urandom_range(0, 19);
      rd = 1'($urandom); wr = 1'($urandom); rw = 1'($urandom);
      iw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      hl = (r == 0);
      if (r == 1) iw = $urandom_range(5, 6);
      if (r == 2) begin rd = 1'b1; dw = 5; end
      run_instr(rd, wr, rw, hl, iw, dw, 0);
      if (halted || timeout_err) begin
        check_sticky(halted ? 3'd6 : 3'd7);
        reset_start();
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM that turns the single-cycle core datapath into a multi-cycle core. It steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and gives each stage its enable. It runs ready-based handshakes with instruction and data memory, and sits between the stage modules and the memories. It also provides halt, memory-timeout error and a retired-instruction counter.

## Interface

- XLEN, 32, width of the retired-instruction counter
- MEM_TIMEOUT, 15, maximum wait cycles per memory transaction; 0 disables the timeout

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching; ignored in every other state
- halt_req  in  1  decoded ebreak/ecall from ID, sampled in DECODE only
- is_mem_read  in  1  ID load flag, sampled in DECODE
- is_mem_write  in  1  ID store flag, sampled in DECODE
- is_reg_write  in  1  ID register-write flag, sampled in DECODE
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction read request
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a write
- if_en  out  1  latch fetched instruction into the IR
- id_en  out  1  decode/register-read enable
- ex_en  out  1  execute enable
- rf_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe; the datapath selects the branch target or PC+4
- busy  out  1  state is FETCH, DECODE, EXECUTE, MEMORY or WRITEBACK
- halted  out  1  state is HALT
- timeout_err  out  1  state is ERROR
- stage  out  3  current state encoding
- retired  out  XLEN  count of completed instructions

## Operation

State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.

- IDLE: all strobes are 0. On start=1, go to FETCH.
- FETCH: imem_req=1. if_en=imem_ready, combinational (Mealy). When imem_ready=1, go to DECODE. Otherwise the wait counter increments.
- DECODE: id_en=1 for one cycle.
  - Latch is_mem_read, is_mem_write and is_reg_write into internal flags.
  - If halt_req=1, go to HALT. Otherwise go to EXECUTE.
- EXECUTE: ex_en=1 for one cycle. If the latched mem_read or mem_write flag is set, go to MEMORY. Otherwise go to WRITEBACK.
- MEMORY: dmem_req=1 and dmem_we=latched mem_write. If both flags are set, the write wins. Hold the request until dmem_ready=1, then go to WRITEBACK.
- WRITEBACK:
  - rf_we=latched reg_write and pc_we=1, for one cycle.
  - retired increments modulo 2^XLEN.
  - Go to FETCH.
- HALT and ERROR are sticky until reset. start is ignored in both.
- Wait counter:
  - Width is clog2(MEM_TIMEOUT+1).
  - Cleared on every entry to FETCH or MEMORY.
  - Increments each cycle in which the request is high and ready is low.
  - If the counter equals MEM_TIMEOUT and ready is still low, go to ERROR at the next edge.
  - A ready that arrives in the cycle the counter reaches MEM_TIMEOUT completes the transaction normally.
- Leaving FETCH or MEMORY deasserts the request the same cycle, including on entry to ERROR.
- All outputs except if_en are decoded from registered state and flags only.
- Latched flags do not change outside DECODE.
- halt_req and the ID flags are don't-care outside DECODE.

## Timing

- Reset (rst=0):
  - State goes to IDLE asynchronously.
  - All outputs are 0, retired=0, latched flags=0, wait counter=0.
  - Requests drop in the same delta as the reset, including mid-transaction.
- The first active edge after rst returns high samples start.
- Latency from start to the first FETCH is 1 edge.
- With zero-wait memories, a non-memory instruction takes 4 cycles (FETCH→DECODE→EXECUTE→WRITEBACK).
- With zero-wait memories, a load or store takes 5 cycles.
- Each memory wait cycle adds 1 cycle.
- rf_we, pc_we, id_en and ex_en are exactly one cycle wide.
- retired updates at the edge that ends WRITEBACK.
- Back-to-back instructions have no bubble: WRITEBACK is followed directly by FETCH.

## Test plan

- Reset, start=1 for 1 cycle, imem_ready=1, ALU instruction with is_reg_write=1 → stage goes 1,2,3,5,1; rf_we=pc_we=1 only in cycle 4; retired=1.
- Load (is_mem_read=1, is_reg_write=1) with dmem_ready held low 3 cycles → MEMORY lasts 4 cycles with dmem_req=1, dmem_we=0; rf_we=1 in WRITEBACK; 8 cycles total.
- Store (is_mem_write=1, is_mem_read=1, is_reg_write=0), zero-wait → dmem_we=1 for 1 cycle; rf_we=0 and pc_we=1 in WRITEBACK; retired increments.
- halt_req=1 in DECODE → stage=6, halted=1, no ex_en, pc_we or rf_we; retired unchanged; a later start pulse has no effect.
- MEM_TIMEOUT=4, imem_ready tied low → after 5 FETCH cycles stage=7, timeout_err=1, imem_req=0; ready=1 on the 5th FETCH cycle instead → normal DECODE.
- rst driven low mid-MEMORY with dmem_req=1 and retired=7 → dmem_req=0 and retired=0 immediately without a clock edge; stage=0 held until start.
